// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state encoding and helpers for the serial pattern transmitter/detector pair
package seq_pkg;

  localparam int SEQ_STATE_W = 2;

  typedef enum logic [SEQ_STATE_W-1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    GAP   = 2'd3
  } seq_state_e;

  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/seq_pattern_tx_if.sv
// rtl/seq_pattern_tx_if.sv - pattern request channel between a requester and seq_pattern_tx
interface seq_pattern_tx_if #(
  parameter int PAT_W = 8
) ();

  localparam int LW = $clog2(PAT_W) + 1;

  logic [PAT_W-1:0] pat_data;
  logic [LW-1:0]    pat_len;
  logic             pat_valid;
  logic             pat_ready;

  modport master (
    output pat_data,
    output pat_len,
    output pat_valid,
    input  pat_ready
  );

  modport slave (
    input  pat_data,
    input  pat_len,
    input  pat_valid,
    output pat_ready
  );

endinterface

// File: rtl/seq_shift_reg.sv
// rtl/seq_shift_reg.sv - pattern shift register: loads so that bit len-1 lands in the MSB, shifts MSB-first
module seq_shift_reg #(
  parameter int PAT_W = 8,
  parameter int LW    = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [PAT_W-1:0] data,
  input  logic [LW-1:0]    len,
  output logic             bit_out
);

  localparam logic [LW-1:0] MAX_LEN = LW'(PAT_W);

  logic [PAT_W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      // len is already clamped, so the shift never exceeds PAT_W
      sr_d = data << (MAX_LEN - len);
    end else if (shift_en) begin
      sr_d = sr_q << 1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign bit_out = sr_q[PAT_W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial pattern transmitter: MSB-first frame, optional parity, idle gap
// Optional trailing even-parity bit enabled by defining SEQ_PATTERN_TX_PARITY_EN.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int PAT_W   = 8,
  parameter int GAP_CYC = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_pattern_tx_if.slave      req,
  output logic                 ser_out,
  output logic                 ser_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int LW = $clog2(PAT_W) + 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  seq_state_e      state_q, state_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            done_q, done_d;

  logic            accept;
  logic            shift_en;
  logic            last_bit;
  logic            cur_bit;
  logic [LW-1:0]   len_c;

  assign accept   = req.pat_valid && (state_q == IDLE);
  assign len_c    = LW'(clamp_len(32'(req.pat_len), PAT_W));
  assign shift_en = (state_q == SHIFT);
  assign last_bit = (cnt_q == LW'(1));

  seq_shift_reg #(
    .PAT_W (PAT_W),
    .LW    (LW)
  ) u_shift (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .shift_en (shift_en),
    .data     (req.pat_data),
    .len      (len_c),
    .bit_out  (cur_bit)
  );

`ifdef SEQ_PATTERN_TX_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (accept) begin
      par_d = 1'b0;
    end else if (shift_en) begin
      par_d = par_q ^ cur_bit;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (len_c == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = SHIFT;
            cnt_d   = len_c;
          end
        end
      end
      SHIFT: begin
        cnt_d = cnt_q - LW'(1);
        if (last_bit) begin
`ifdef SEQ_PATTERN_TX_PARITY_EN
          state_d = PAR;
`else
          done_d  = 1'b1;
          state_d = (GAP_CYC == 0) ? IDLE : GAP;
          gap_d   = GW'(GAP_CYC - 1);
`endif
        end
      end
`ifdef SEQ_PATTERN_TX_PARITY_EN
      PAR: begin
        done_d  = 1'b1;
        state_d = (GAP_CYC == 0) ? IDLE : GAP;
        gap_d   = GW'(GAP_CYC - 1);
      end
`endif
      GAP: begin
        // gap_q counts down to zero, giving exactly GAP_CYC cycles here
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    req.pat_ready = (state_q == IDLE);
    busy          = (state_q != IDLE);
    done          = done_q;
    ser_valid     = 1'b0;
    ser_out       = 1'b0;
    if (state_q == SHIFT) begin
      ser_valid = 1'b1;
      ser_out   = cur_bit;
    end
`ifdef SEQ_PATTERN_TX_PARITY_EN
    if (state_q == PAR) begin
      ser_valid = 1'b1;
      ser_out   = par_q;
    end
`endif
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - randomized self-checking bench for seq_pattern_tx against a frame-level model
module tb_seq_pattern_tx;

  localparam int PAT_W = 8;
  localparam int LW    = $clog2(PAT_W) + 1;
  localparam int GAP_A = 2;
  localparam int GAP_B = 0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // observation word per cycle: {pat_ready, busy, ser_valid, ser_out, done}
  localparam logic [4:0] OBS_IDLE = 5'b10000;
  localparam logic [4:0] OBS_DONE = 5'b10001;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [PAT_W-1:0] drv_data  [2];
  logic [LW-1:0]    drv_len   [2];
  logic             drv_valid [2];

  logic so_a, sv_a, busy_a, done_a;
  logic so_b, sv_b, busy_b, done_b;

  logic [4:0] exp_q [$];

  seq_pattern_tx_if #(.PAT_W(PAT_W)) if_a ();
  seq_pattern_tx_if #(.PAT_W(PAT_W)) if_b ();

  assign if_a.pat_data  = drv_data[0];
  assign if_a.pat_len   = drv_len[0];
  assign if_a.pat_valid = drv_valid[0];
  assign if_b.pat_data  = drv_data[1];
  assign if_b.pat_len   = drv_len[1];
  assign if_b.pat_valid = drv_valid[1];

  seq_pattern_tx #(.PAT_W(PAT_W), .GAP_CYC(GAP_A)) u_dut_gap (
    .clk       (clk),
    .reset     (rst_n),
    .req       (if_a),
    .ser_out   (so_a),
    .ser_valid (sv_a),
    .busy      (busy_a),
    .done      (done_a)
  );

  seq_pattern_tx #(.PAT_W(PAT_W), .GAP_CYC(GAP_B)) u_dut_nogap (
    .clk       (clk),
    .reset     (rst_n),
    .req       (if_b),
    .ser_out   (so_b),
    .ser_valid (sv_b),
    .busy      (busy_b),
    .done      (done_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] get_obs(input int s);
    if (s == 0) return {if_a.pat_ready, busy_a, sv_a, so_a, done_a};
    return {if_b.pat_ready, busy_b, sv_b, so_b, done_b};
  endfunction

  function automatic int gap_of(input int s);
    return (s == 0) ? GAP_A : GAP_B;
  endfunction

  // Expected per-cycle trace starting the cycle after accept.
  function automatic void push_frame(input logic [PAT_W-1:0] d, input int l, input int gap, input bit tail);
    int   len;
    logic par;
    len = (l > PAT_W) ? PAT_W : l;
    par = 1'b0;
    if (len == 0) begin
      exp_q.push_back(OBS_DONE);
    end else begin
      for (int i = len - 1; i >= 0; i--) begin
        exp_q.push_back({3'b011, d[i], 1'b0});
        par = par ^ d[i];
      end
      if (PAR_EN) exp_q.push_back({3'b011, par, 1'b0});
      if (gap == 0) begin
        exp_q.push_back(OBS_DONE);
      end else begin
        for (int g = 0; g < gap; g++) exp_q.push_back({4'b0100, (g == 0)});
      end
    end
    if (tail) exp_q.push_back(OBS_IDLE);
  endfunction

  task automatic play(input int s, input string tag, input bit hold);
    int         n;
    logic [4:0] e;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q[i];
      check_eq($sformatf("%s[%0d]", tag, i), 32'(get_obs(s)), 32'(e));
      if (hold && i != n - 1) begin
        drv_valid[s] = 1'b1;
      end else begin
        drv_valid[s] = e[4] ? 1'b0 : 1'($urandom_range(0, 1));
        if (!hold) begin
          drv_data[s] = PAT_W'($urandom);
          drv_len[s]  = LW'($urandom);
        end
      end
      @(negedge clk);
    end
    exp_q.delete();
  endtask

  task automatic send(input int s, input logic [PAT_W-1:0] d, input int l, output bit ok);
    int         n;
    logic [4:0] o;
    drv_data[s]  = d;
    drv_len[s]   = LW'(l);
    drv_valid[s] = 1'b1;
    n = 0;
    o = get_obs(s);
    while (o[4] !== 1'b1 && n < 50) begin
      @(negedge clk);
      o = get_obs(s);
      n++;
    end
    ok = (o[4] === 1'b1);
    if (!ok) begin
      check_eq("accept_timeout", 32'(o[4]), 32'd1);
      drv_valid[s] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic run_frame(input int s, input string tag, input logic [PAT_W-1:0] d, input int l);
    bit ok;
    send(s, d, l, ok);
    if (ok) begin
      push_frame(d, l, gap_of(s), 1'b1);
      play(s, tag, 1'b0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    for (int s = 0; s < 2; s++) begin
      drv_data[s]  = '0;
      drv_len[s]   = '0;
      drv_valid[s] = 1'b0;
    end

    @(negedge clk);
    check_eq("reset_a", 32'(get_obs(0)), 32'(OBS_IDLE));
    check_eq("reset_b", 32'(get_obs(1)), 32'(OBS_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    run_frame(0, "len3_gap2", 8'b0000_0101, 3);
    run_frame(0, "len0_gap2", 8'hFF, 0);
    run_frame(1, "len0_nogap", 8'h5A, 0);
    run_frame(0, "clamp12", 8'hA5, 12);
    run_frame(1, "clamp8_nogap", 8'h3C, 8);
`ifdef SEQ_PATTERN_TX_PARITY_EN
    run_frame(0, "parity111", 8'h07, 3);
`endif

    // request held high across two frames with no gap
    send(1, 8'h0D, 4, ok);
    if (ok) begin
      drv_data[1] = 8'h02;
      drv_len[1]  = LW'(2);
      push_frame(8'h0D, 4, GAP_B, 1'b0);
      push_frame(8'h02, 2, GAP_B, 1'b0);
      play(1, "b2b", 1'b1);
      check_eq("b2b_idle", 32'(get_obs(1)), 32'(OBS_IDLE));
    end

    for (int k = 0; k < 16; k++) begin
      run_frame(0, $sformatf("rnd_a%0d", k), PAT_W'($urandom), $urandom_range(0, 12));
      run_frame(1, $sformatf("rnd_b%0d", k), PAT_W'($urandom), $urandom_range(0, 12));
    end

    // abort after 2 of 5 bits
    send(0, 8'b0001_0110, 5, ok);
    if (ok) begin
      drv_valid[0] = 1'b0;
      check_eq("abort_bit0", 32'(get_obs(0)), 32'(5'b01110));
      @(negedge clk);
      check_eq("abort_bit1", 32'(get_obs(0)), 32'(5'b01100));
      #2 rst_n = 1'b0;
      #1;
      check_eq("abort_async_a", 32'(get_obs(0)), 32'(OBS_IDLE));
      check_eq("abort_async_b", 32'(get_obs(1)), 32'(OBS_IDLE));
      @(negedge clk);
      check_eq("abort_hold", 32'(get_obs(0)), 32'(OBS_IDLE));
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check_eq($sformatf("abort_idle[%0d]", i), 32'(get_obs(0)), 32'(OBS_IDLE));
      end
    end

    run_frame(0, "post_abort", 8'h96, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 SHALL have parameter PAT_W, default 8: maximum pattern length in bits.
REQ-002 SHALL have parameter GAP_CYC, default 2: idle cycles inserted after each frame (0 allowed).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port pat_data, input, PAT_W: pattern; bit pat_len-1 is sent first.
REQ-006 SHALL have port pat_len, input, $clog2(PAT_W)+1: number of bits to send.
REQ-007 SHALL have port pat_valid, input, 1: request to send, held until accepted.
REQ-008 SHALL have port pat_ready, output, 1: block can accept a request.
REQ-009 SHALL have port ser_out, output, 1: serial bit stream, suitable for driving a sequence detector's in.
REQ-010 SHALL have port ser_valid, output, 1: ser_out carries a frame bit this cycle.
REQ-011 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-012 SHALL have port done, output, 1: one-cycle end-of-frame pulse.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, PAR (present only when parity is enabled) and GAP.
REQ-014 SHALL drive pat_ready=1 only in IDLE; accept on the edge where pat_valid&&pat_ready, latching pat_data and pat_len.
REQ-015 SHALL clamp pat_len>PAT_W to PAT_W at accept.
REQ-016 SHALL, for accepted len>=1, enter SHIFT and drive bits len-1..0 on ser_out on consecutive cycles with ser_valid=1; first bit appears in the cycle after accept.
REQ-017 SHALL, after the last data bit, go to PAR if enabled, else to GAP; or to IDLE when GAP_CYC=0.
REQ-018 SHALL hold ser_out=0 and ser_valid=0 in GAP for exactly GAP_CYC cycles, then return to IDLE.
REQ-019 SHALL pulse done for exactly one cycle: the cycle after the final frame bit (data or parity).
REQ-020 SHALL, for an accepted len=0, emit no bits, pulse done in the cycle after accept and stay in IDLE; no gap is inserted.
REQ-021 SHALL drive ser_out=0 whenever ser_valid=0.
REQ-022 SHALL ignore pat_valid and input changes while busy; the latched frame is not affected.
REQ-023 SHALL support back-to-back frames: a request held high is accepted on the first IDLE cycle.

Reset
REQ-024 SHALL, on reset low, immediately force state=IDLE, pat_ready=1, ser_out=0, ser_valid=0, busy=0, done=0 and clear latched data.
REQ-025 SHALL abort a frame in progress when reset is asserted mid-frame, with no done pulse; the frame does not resume after reset release.

Configuration
REQ-026 SHALL, with SEQ_PATTERN_TX_PARITY_EN defined, emit one extra bit in PAR with ser_valid=1: the even parity (XOR) of the len transmitted bits.
REQ-027 SHALL, without SEQ_PATTERN_TX_PARITY_EN, omit the PAR state and parity logic; frames are exactly len bits.

Structure
REQ-028 SHALL place the state encoding typedef and the IDLE/SHIFT/PAR/GAP constants in the shared package seq_pkg, for reuse by the detector side.
REQ-029 SHALL factor the load/shift datapath into a sub-module named seq_shift_reg (parallel load, MSB-select by length, shift enable).

Verification
REQ-030 SHALL verify: pat_data=8'b0000_0101, len=3 -> ser_out 1,0,1 with ser_valid=1 for 3 cycles; done in the 4th cycle; 2 GAP cycles; then pat_ready=1.
REQ-031 SHALL verify: len=0 -> no ser_valid; done one cycle after accept; pat_ready=1 on the next cycle.
REQ-032 SHALL verify: len=12 with PAT_W=8 -> exactly 8 bits sent, MSB (bit 7) first.
REQ-033 SHALL verify: pat_valid held high over two frames with GAP_CYC=0 -> the second frame's first bit immediately follows the first frame's done cycle.
REQ-034 SHALL verify: reset pulled low after 2 of 5 bits -> outputs go to reset values asynchronously, no done pulse, and IDLE after release.
REQ-035 SHALL verify: with SEQ_PATTERN_TX_PARITY_EN, pattern 3'b111 -> ser_out 1,1,1,1 (parity bit 1), then done.
